// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage of the 5-stage RV64 pipeline. Owns
//                the program counter, presents it to instruction memory every
//                cycle and captures the returned word into the IF/ID register.
//                Handles load-use stall, branch redirect/flush, end-of-program
//                detection, a sticky misaligned-target flag and a counter of
//                valid instructions loaded into IF/ID.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   1   rising-edge clock
//    reset             in   1   synchronous active-high reset
//    stall             in   1   hold PC, IF/ID and fetch_count
//    branch_taken      in   1   redirect to branch_target, flush IF/ID
//    branch_target     in  64   redirect byte address
//    inst_address      out 64   fetch address to instruction memory (= pc)
//    instruction_in    in  32   instruction memory read data for inst_address
//    if_id_pc          out 64   PC of the instruction held in IF/ID
//    if_id_instruction out 32   instruction held in IF/ID
//    if_id_valid       out  1   IF/ID holds a real instruction
//    fetch_done        out  1   pc is past the end of program
//    misaligned_fault  out  1   sticky: a redirect target was not word aligned
//    fetch_count       out 32   valid instructions loaded since reset
// ============================================================================
module fetch_unit #(
   parameter logic [63:0] RESET_PC   = 64'd0,
   parameter logic [63:0] IMEM_BYTES = 64'd124,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic [63:0] inst_address,
   input  logic [31:0] instruction_in,
   output logic [63:0] if_id_pc,
   output logic [31:0] if_id_instruction,
   output logic        if_id_valid,
   output logic        fetch_done,
   output logic        misaligned_fault,
   output logic [31:0] fetch_count
);

   logic [63:0] pc_q,          pc_d;
   logic [63:0] if_id_pc_q,    if_id_pc_d;
   logic [31:0] if_id_inst_q,  if_id_inst_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic        fault_q,       fault_d;
   logic [31:0] count_q,       count_d;
   logic        done_w;

   // End of program is judged on the registered pc only, so fetch_done never
   // depends combinationally on any input.
   assign done_w = (pc_q >= IMEM_BYTES);

   always_comb begin
      // Default: everything holds (covers the stall case).
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_inst_d  = if_id_inst_q;
      if_id_valid_d = if_id_valid_q;
      fault_d       = fault_q;
      count_d       = count_q;

      if (branch_taken) begin
         // Redirect wins over stall; the word fetched this cycle is dropped
         // and replaced by a bubble. Low address bits are forced to zero and
         // a non-zero value is remembered as a sticky fault.
         pc_d          = {branch_target[63:2], 2'b00};
         if_id_pc_d    = 64'd0;
         if_id_inst_d  = NOP_INST;
         if_id_valid_d = 1'b0;
         if (branch_target[1:0] != 2'b00) begin
            fault_d = 1'b1;
         end
      end else if (stall) begin
         // hold
      end else if (done_w) begin
         // Past the end: park the pc and keep feeding bubbles. instruction_in
         // is deliberately not looked at here.
         if_id_pc_d    = 64'd0;
         if_id_inst_d  = NOP_INST;
         if_id_valid_d = 1'b0;
      end else begin
         pc_d          = pc_q + 64'd4;
         if_id_pc_d    = pc_q;
         if_id_inst_d  = instruction_in;
         if_id_valid_d = 1'b1;
         count_d       = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         if_id_pc_q    <= 64'd0;
         if_id_inst_q  <= NOP_INST;
         if_id_valid_q <= 1'b0;
         fault_q       <= 1'b0;
         count_q       <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_inst_q  <= if_id_inst_d;
         if_id_valid_q <= if_id_valid_d;
         fault_q       <= fault_d;
         count_q       <= count_d;
      end
   end

   assign inst_address      = pc_q;
   assign fetch_done        = done_w;
   assign if_id_pc          = if_id_pc_q;
   assign if_id_instruction = if_id_inst_q;
   assign if_id_valid       = if_id_valid_q;
   assign misaligned_fault  = fault_q;
   assign fetch_count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A small reference model
//                of the fetch rules is checked against the DUT every cycle,
//                alongside hand-computed expectations at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [63:0] c_IMEM = 64'd124;
   localparam logic [31:0] c_NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [63:0] inst_address;
   logic [31:0] instruction_in;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instruction;
   logic        if_id_valid;
   logic        fetch_done;
   logic        misaligned_fault;
   logic [31:0] fetch_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .inst_address      (inst_address),
      .instruction_in    (instruction_in),
      .if_id_pc          (if_id_pc),
      .if_id_instruction (if_id_instruction),
      .if_id_valid       (if_id_valid),
      .fetch_done        (fetch_done),
      .misaligned_fault  (misaligned_fault),
      .fetch_count       (fetch_count)
   );

   // Instruction memory: word 0 holds the test-plan instruction, the rest a
   // distinct pattern so a wrong fetch address shows up. Beyond the end the
   // contents are garbage.
   function automatic logic [31:0] mem_word(input logic [63:0] addr);
      if (addr >= c_IMEM)        return 32'hDEAD_BEEF;
      if (addr[63:2] == 62'd0)   return 32'h0040_0293;
      return 32'hA000_0000 | 32'(addr);
   endfunction

   always_comb instruction_in = mem_word(inst_address);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] m_pc, m_ipc;
   logic [31:0] m_inst, m_cnt;
   logic        m_valid, m_fault;
   bit          m_ok = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_pc = 64'd0; m_ipc = 64'd0; m_inst = c_NOP; m_valid = 1'b0;
         m_fault = 1'b0; m_cnt = 32'd0; m_ok = 1'b1;
      end else if (m_ok) begin
         if (branch_taken) begin
            m_pc    = branch_target & ~64'd3;
            m_ipc   = 64'd0; m_inst = c_NOP; m_valid = 1'b0;
            if (branch_target % 4 != 0) m_fault = 1'b1;
         end else if (stall) begin
            // nothing moves
         end else if (m_pc >= c_IMEM) begin
            m_ipc = 64'd0; m_inst = c_NOP; m_valid = 1'b0;
         end else begin
            m_ipc   = m_pc;
            m_inst  = mem_word(m_pc);
            m_valid = 1'b1;
            m_cnt   = m_cnt + 1;
            m_pc    = m_pc + 4;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("model.inst_address", inst_address, m_pc);
         chk("model.fetch_done",   64'(fetch_done), 64'(m_pc >= c_IMEM));
         chk("model.if_id_pc",     if_id_pc, m_ipc);
         chk("model.if_id_inst",   64'(if_id_instruction), 64'(m_inst));
         chk("model.if_id_valid",  64'(if_id_valid), 64'(m_valid));
         chk("model.fault",        64'(misaligned_fault), 64'(m_fault));
         chk("model.fetch_count",  64'(fetch_count), 64'(m_cnt));
      end
   end

   // Apply one cycle of inputs; returns at the following falling edge.
   task automatic step(input logic r, input logic s, input logic b, input logic [63:0] t);
      reset = r; stall = s; branch_taken = b; branch_target = t;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 64'd0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;

      // Reset for two cycles.
      step(1'b1, 1'b0, 1'b0, 64'd0);
      step(1'b1, 1'b0, 1'b0, 64'd0);
      chk("rst.addr",  inst_address, 64'h0);
      chk("rst.inst",  64'(if_id_instruction), 64'h13);
      chk("rst.valid", 64'(if_id_valid), 64'd0);
      chk("rst.count", 64'(fetch_count), 64'd0);
      chk("rst.fault", 64'(misaligned_fault), 64'd0);

      // First fetch.
      run(1);
      chk("first.pc",    if_id_pc, 64'h0);
      chk("first.inst",  64'(if_id_instruction), 64'h0040_0293);
      chk("first.valid", 64'(if_id_valid), 64'd1);
      chk("first.addr",  inst_address, 64'h4);
      chk("first.count", 64'(fetch_count), 64'd1);

      // Five normal cycles total, then a three-cycle stall.
      run(4);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 64'd0);
         chk("stall.addr",  inst_address, 64'h14);
         chk("stall.pc",    if_id_pc, 64'h10);
         chk("stall.count", 64'(fetch_count), 64'd5);
      end
      run(1);
      chk("unstall.addr",  inst_address, 64'h18);
      chk("unstall.count", 64'(fetch_count), 64'd6);

      // Branch together with stall: branch wins.
      step(1'b0, 1'b1, 1'b1, 64'h28);
      chk("br.addr",  inst_address, 64'h28);
      chk("br.valid", 64'(if_id_valid), 64'd0);
      chk("br.inst",  64'(if_id_instruction), 64'h13);
      chk("br.count", 64'(fetch_count), 64'd6);
      run(1);
      chk("br2.pc",    if_id_pc, 64'h28);
      chk("br2.valid", 64'(if_id_valid), 64'd1);
      chk("br2.count", 64'(fetch_count), 64'd7);

      // Run to the end of program (0x2C -> 0x7C is 20 fetches).
      run(20);
      chk("end.addr", inst_address, 64'h7C);
      chk("end.done", 64'(fetch_done), 64'd1);
      chk("end.lastpc", if_id_pc, 64'h78);
      run(2);
      chk("end.hold",  inst_address, 64'h7C);
      chk("end.valid", 64'(if_id_valid), 64'd0);
      chk("end.inst",  64'(if_id_instruction), 64'h13);
      chk("end.count", 64'(fetch_count), 64'd27);

      // Redirect back into the program.
      step(1'b0, 1'b0, 1'b1, 64'h2C);
      chk("resume.addr", inst_address, 64'h2C);
      chk("resume.done", 64'(fetch_done), 64'd0);
      run(1);
      chk("resume.pc",    if_id_pc, 64'h2C);
      chk("resume.count", 64'(fetch_count), 64'd28);

      // Misaligned redirect; fault is sticky across later redirects.
      step(1'b0, 1'b0, 1'b1, 64'h2A);
      chk("mis.addr",  inst_address, 64'h28);
      chk("mis.fault", 64'(misaligned_fault), 64'd1);
      step(1'b0, 1'b0, 1'b1, 64'h10);
      chk("mis.sticky", 64'(misaligned_fault), 64'd1);
      run(12);
      chk("pre_rst.addr", inst_address, 64'h40);

      // Reset during a stall.
      step(1'b0, 1'b1, 1'b0, 64'd0);
      step(1'b1, 1'b1, 1'b0, 64'd0);
      chk("midrst.addr",  inst_address, 64'h0);
      chk("midrst.fault", 64'(misaligned_fault), 64'd0);
      chk("midrst.count", 64'(fetch_count), 64'd0);
      chk("midrst.valid", 64'(if_id_valid), 64'd0);
      run(1);
      chk("restart.pc",   if_id_pc, 64'h0);
      chk("restart.addr", inst_address, 64'h4);
      chk("restart.valid", 64'(if_id_valid), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
